// File: rtl/dual_port_ram_pkg.sv
// Shared types and constants for the dual-port RAM.
//   ram_state_e : clear sequencer state (CLEAR after reset, RUN for normal access)
//   RDW_OLD/NEW : read-during-write mode selectors
//   params_ok() : elaboration-time sanity check of the RAM geometry
package dual_port_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Latency must be 1 or 2 and every word must be reachable by an addr-bit address.
    function automatic bit params_ok(input int unsigned rd_lat, input int unsigned depth,
                                     input int unsigned addr);
        if (rd_lat != 1 && rd_lat != 2) return 1'b0;
        if (addr == 0 || addr > 32) return 1'b0;
        if (depth == 0) return 1'b0;
        if (addr < 32 && ((depth - 1) >> addr) != 0) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read latency stage: a data + valid shift register rd_lat stages long.
// A stage only loads data when its input is valid, so the output holds the last
// completed read while valid_out is low. rst flushes every stage to zero.
//   clk, rst  : clock, synchronous active-high reset
//   valid_in  : read accepted this cycle
//   data_in   : word selected for that read
//   valid_out : 1-cycle pulse when the read completes
//   data_out  : last completed read data
module ram_rd_pipe #(
    parameter int unsigned width  = 8,
    parameter int unsigned rd_lat = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [width-1:0] data_in,
    output logic             valid_out,
    output logic [width-1:0] data_out
);

    logic [rd_lat-1:0] valid_q, valid_d;
    logic [width-1:0]  data_q [rd_lat];
    logic [width-1:0]  data_d [rd_lat];

    // Input of each stage: stage 0 from the port, stage s from stage s-1.
    logic [rd_lat-1:0] v_chain;
    logic [width-1:0]  d_chain [rd_lat];

    always_comb begin
        v_chain[0] = valid_in;
        d_chain[0] = data_in;
        for (int s = 1; s < rd_lat; s++) begin
            v_chain[s] = valid_q[s-1];
            d_chain[s] = data_q[s-1];
        end
        for (int s = 0; s < rd_lat; s++) begin
            valid_d[s] = v_chain[s];
            data_d[s]  = v_chain[s] ? d_chain[s] : data_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < rd_lat; s++) data_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < rd_lat; s++) data_q[s] <= data_d[s];
        end
    end

    assign valid_out = valid_q[rd_lat-1];
    assign data_out  = data_q[rd_lat-1];

endmodule

// File: rtl/dual_port_ram_pipe.sv
// True dual-port RAM with configurable read latency, read-during-write mode,
// port-0-wins write arbitration, post-reset clear sequencer and address check.
//   clk, rst                  : clock, synchronous active-high reset
//   rd_enN, rd_addrN          : port N read request
//   wr_enN, wr_addrN, data_inN: port N write request
//   data_outN, rd_validN      : port N read data and completion pulse
//   init_busy                 : clear sequence running, all requests ignored
//   wr_collision              : pulse, both ports wrote the same address
//   addr_err                  : pulse, an accepted request addressed >= depth
module dual_port_ram_pipe
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned     width    = 8,
    parameter int unsigned     depth    = 256,
    parameter int unsigned     addr     = 8,
    parameter int unsigned     rd_lat   = 1,
    parameter int unsigned     rdw_mode = 0,
    parameter logic [width-1:0] clr_val = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en0,
    input  logic             wr_en0,
    input  logic [addr-1:0]  rd_addr0,
    input  logic [addr-1:0]  wr_addr0,
    input  logic [width-1:0] data_in0,
    output logic [width-1:0] data_out0,
    output logic             rd_valid0,
    input  logic             rd_en1,
    input  logic             wr_en1,
    input  logic [addr-1:0]  rd_addr1,
    input  logic [addr-1:0]  wr_addr1,
    input  logic [width-1:0] data_in1,
    output logic [width-1:0] data_out1,
    output logic             rd_valid1,
    output logic             init_busy,
    output logic             wr_collision,
    output logic             addr_err
);

    if (!params_ok(rd_lat, depth, addr)) begin : gen_bad_params
        $error("dual_port_ram_pipe: illegal rd_lat/depth/addr combination");
    end

    localparam logic [addr-1:0] LastAddr = addr'(depth - 1);

    function automatic logic in_range(input logic [addr-1:0] a);
        return 32'(a) < depth;
    endfunction

    logic [width-1:0] mem_q [depth];

    ram_state_e      state_q, state_d;
    logic [addr-1:0] clr_ptr_q, clr_ptr_d;
    logic            wr_collision_q, wr_collision_d;
    logic            addr_err_q, addr_err_d;

    logic             accept, clr_we, collision;
    logic             rd_ok0, rd_ok1, wr_ok0, wr_ok1;
    logic             we0, we1;
    logic [width-1:0] rd_word0, rd_word1;

    // Requests are honoured only in RUN and never in a reset cycle.
    assign accept = (state_q == RUN) && !rst;
    assign clr_we = (state_q == CLEAR) && !rst;

    assign rd_ok0 = in_range(rd_addr0);
    assign rd_ok1 = in_range(rd_addr1);
    assign wr_ok0 = in_range(wr_addr0);
    assign wr_ok1 = in_range(wr_addr1);

    // Port 0 wins a same-address write; port 1's write is dropped.
    assign collision = wr_en0 && wr_en1 && (wr_addr0 == wr_addr1);
    assign we0       = accept && wr_en0 && wr_ok0;
    assign we1       = accept && wr_en1 && wr_ok1 && !collision;

    // Read word selection: out-of-range reads return 0; in write-first mode a
    // read of an address being written this cycle sees the winning write data.
    always_comb begin
        rd_word0 = '0;
        if (rd_ok0) begin
            rd_word0 = mem_q[rd_addr0];
            if (rdw_mode == RDW_NEW) begin
                if (we0 && wr_addr0 == rd_addr0) begin
                    rd_word0 = data_in0;
                end else if (we1 && wr_addr1 == rd_addr0) begin
                    rd_word0 = data_in1;
                end
            end
        end
    end

    always_comb begin
        rd_word1 = '0;
        if (rd_ok1) begin
            rd_word1 = mem_q[rd_addr1];
            if (rdw_mode == RDW_NEW) begin
                if (we0 && wr_addr0 == rd_addr1) begin
                    rd_word1 = data_in0;
                end else if (we1 && wr_addr1 == rd_addr1) begin
                    rd_word1 = data_in1;
                end
            end
        end
    end

    // Clear sequencer and flag next state.
    always_comb begin
        state_d        = state_q;
        clr_ptr_d      = clr_ptr_q;
        wr_collision_d = accept && collision;
        addr_err_d     = accept && ((rd_en0 && !rd_ok0) || (rd_en1 && !rd_ok1) ||
                                    (wr_en0 && !wr_ok0) || (wr_en1 && !wr_ok1));
        unique case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LastAddr) state_d = RUN;
            end
            RUN: ;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CLEAR;
            clr_ptr_q      <= '0;
            wr_collision_q <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_ptr_q      <= clr_ptr_d;
            wr_collision_q <= wr_collision_d;
            addr_err_q     <= addr_err_d;
        end
    end

    // Storage is not reset; the clear sequencer initialises it instead.
    always_ff @(posedge clk) begin
        if (clr_we) mem_q[clr_ptr_q] <= clr_val;
        if (we0)    mem_q[wr_addr0]  <= data_in0;
        if (we1)    mem_q[wr_addr1]  <= data_in1;
    end

    ram_rd_pipe #(
        .width  (width),
        .rd_lat (rd_lat)
    ) u_rd_pipe0 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (accept && rd_en0),
        .data_in   (rd_word0),
        .valid_out (rd_valid0),
        .data_out  (data_out0)
    );

    ram_rd_pipe #(
        .width  (width),
        .rd_lat (rd_lat)
    ) u_rd_pipe1 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (accept && rd_en1),
        .data_in   (rd_word1),
        .valid_out (rd_valid1),
        .data_out  (data_out1)
    );

    assign init_busy    = (state_q == CLEAR);
    assign wr_collision = wr_collision_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Bench for dual_port_ram_pipe. Two instances share one stimulus stream:
//   dut 0: depth 256, rd_lat 1, read-first,  clr_val 00
//   dut 1: depth 200, rd_lat 2, write-first, clr_val 5A
// Each has its own reference model: a word array, a clear countdown and a
// ring of reads scheduled to complete at a given cycle.
module tb_dual_port_ram_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_en   [2];
    logic       wr_en   [2];
    logic [7:0] rd_addr [2];
    logic [7:0] wr_addr [2];
    logic [7:0] din     [2];

    logic [7:0] dout [2][2];
    logic       vld  [2][2];
    logic       busy [2];
    logic       coll [2];
    logic       aerr [2];

    always #5 clk = ~clk;

    dual_port_ram_pipe #(
        .width(8), .depth(256), .addr(8), .rd_lat(1), .rdw_mode(0), .clr_val(8'h00)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .rd_en0(rd_en[0]), .wr_en0(wr_en[0]), .rd_addr0(rd_addr[0]), .wr_addr0(wr_addr[0]),
        .data_in0(din[0]), .data_out0(dout[0][0]), .rd_valid0(vld[0][0]),
        .rd_en1(rd_en[1]), .wr_en1(wr_en[1]), .rd_addr1(rd_addr[1]), .wr_addr1(wr_addr[1]),
        .data_in1(din[1]), .data_out1(dout[0][1]), .rd_valid1(vld[0][1]),
        .init_busy(busy[0]), .wr_collision(coll[0]), .addr_err(aerr[0])
    );

    dual_port_ram_pipe #(
        .width(8), .depth(200), .addr(8), .rd_lat(2), .rdw_mode(1), .clr_val(8'h5A)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .rd_en0(rd_en[0]), .wr_en0(wr_en[0]), .rd_addr0(rd_addr[0]), .wr_addr0(wr_addr[0]),
        .data_in0(din[0]), .data_out0(dout[1][0]), .rd_valid0(vld[1][0]),
        .rd_en1(rd_en[1]), .wr_en1(wr_en[1]), .rd_addr1(rd_addr[1]), .wr_addr1(wr_addr[1]),
        .data_in1(din[1]), .data_out1(dout[1][1]), .rd_valid1(vld[1][1]),
        .init_busy(busy[1]), .wr_collision(coll[1]), .addr_err(aerr[1])
    );

    // Per-instance configuration seen by the model.
    int unsigned m_depth [2] = '{256, 200};
    int unsigned m_lat   [2] = '{1, 2};
    int unsigned m_rdw   [2] = '{0, 1};
    logic [7:0]  m_clrv  [2] = '{8'h00, 8'h5A};

    // Model state.
    logic [7:0]  m_mem  [2][256];
    bit          m_busy [2];
    int unsigned m_clr  [2];
    bit          due_v  [2][2][4];
    logic [7:0]  due_d  [2][2][4];
    logic [7:0]  exp_dout [2][2];
    bit          exp_vld  [2][2];
    bit          exp_coll [2];
    bit          exp_err  [2];
    int unsigned edge_n = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Advance instance i's model by one clock edge using the current inputs.
    task automatic model_step(input int i);
        int unsigned slot;
        logic [7:0]  v;
        bit          same, ok0, ok1;
        if (rst) begin
            m_busy[i] = 1'b1;
            m_clr[i]  = 0;
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < 4; s++) due_v[i][p][s] = 1'b0;
                exp_vld[i][p]  = 1'b0;
                exp_dout[i][p] = 8'h00;
            end
            exp_coll[i] = 1'b0;
            exp_err[i]  = 1'b0;
            return;
        end
        exp_coll[i] = 1'b0;
        exp_err[i]  = 1'b0;
        if (m_busy[i]) begin
            m_mem[i][m_clr[i]] = m_clrv[i];
            m_clr[i]++;
            if (m_clr[i] == m_depth[i]) m_busy[i] = 1'b0;
        end else begin
            same = wr_en[0] && wr_en[1] && (wr_addr[0] == wr_addr[1]);
            ok0  = wr_en[0] && (wr_addr[0] < m_depth[i]);
            ok1  = wr_en[1] && (wr_addr[1] < m_depth[i]) && !same;
            exp_coll[i] = same;
            for (int p = 0; p < 2; p++) begin
                if ((rd_en[p] && rd_addr[p] >= m_depth[i]) ||
                    (wr_en[p] && wr_addr[p] >= m_depth[i])) exp_err[i] = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) begin
                    if (rd_addr[p] >= m_depth[i]) v = 8'h00;
                    else if (m_rdw[i] == 1 && ok0 && wr_addr[0] == rd_addr[p]) v = din[0];
                    else if (m_rdw[i] == 1 && ok1 && wr_addr[1] == rd_addr[p]) v = din[1];
                    else v = m_mem[i][rd_addr[p]];
                    slot = (edge_n + m_lat[i] - 1) % 4;
                    due_v[i][p][slot] = 1'b1;
                    due_d[i][p][slot] = v;
                end
            end
            if (ok0) m_mem[i][wr_addr[0]] = din[0];
            if (ok1) m_mem[i][wr_addr[1]] = din[1];
        end
        slot = edge_n % 4;
        for (int p = 0; p < 2; p++) begin
            exp_vld[i][p] = due_v[i][p][slot];
            if (due_v[i][p][slot]) exp_dout[i][p] = due_d[i][p][slot];
            due_v[i][p][slot] = 1'b0;
        end
    endtask

    // One clock: update both models, take the edge, compare every output.
    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                check_eq($sformatf("dut%0d.data_out%0d", i, p), 32'(dout[i][p]),
                         32'(exp_dout[i][p]));
                check_eq($sformatf("dut%0d.rd_valid%0d", i, p), 32'(vld[i][p]),
                         32'(exp_vld[i][p]));
            end
            check_eq($sformatf("dut%0d.init_busy", i), 32'(busy[i]), 32'(m_busy[i]));
            check_eq($sformatf("dut%0d.wr_collision", i), 32'(coll[i]), 32'(exp_coll[i]));
            check_eq($sformatf("dut%0d.addr_err", i), 32'(aerr[i]), 32'(exp_err[i]));
        end
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            rd_en[p]   = 1'b0;
            wr_en[p]   = 1'b0;
            rd_addr[p] = 8'h00;
            wr_addr[p] = 8'h00;
            din[p]     = 8'h00;
        end
    endtask

    task automatic do_write(input int p, input logic [7:0] a, input logic [7:0] d);
        wr_en[p]   = 1'b1;
        wr_addr[p] = a;
        din[p]     = d;
    endtask

    task automatic do_read(input int p, input logic [7:0] a);
        rd_en[p]   = 1'b1;
        rd_addr[p] = a;
    endtask

    // Wait for both instances to finish clearing; returns the edge counts.
    task automatic wait_clear(output int cnt_a, output int cnt_b);
        bit done_a = 1'b0;
        bit done_b = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 400 && !(done_a && done_b); c++) begin
            step();
            if (!done_a) begin
                cnt_a++;
                if (!busy[0]) done_a = 1'b1;
            end
            if (!done_b) begin
                cnt_b++;
                if (!busy[1]) done_b = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom);
            1:       return 8'($urandom_range(196, 203));
            default: return 8'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        int ca, cb;
        idle();

        // Reset and clear length.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        wait_clear(ca, cb);
        check_eq("busy_len_a", 32'(ca), 32'd256);
        check_eq("busy_len_b", 32'(cb), 32'd200);

        // Top word reads back the clear value on dut 0.
        do_read(1, 8'hFF);
        step();
        idle();
        check_eq("clr_rd_a_data", 32'(dout[0][1]), 32'h00);
        check_eq("clr_rd_a_vld", 32'(vld[0][1]), 32'h1);
        step();

        // Basic access on both ports.
        do_write(0, 8'h0A, 8'h55);
        do_write(1, 8'h0B, 8'hAA);
        step();
        idle();
        do_read(0, 8'h0A);
        do_read(1, 8'h0B);
        step();
        idle();
        check_eq("basic_a_d0", 32'(dout[0][0]), 32'h55);
        check_eq("basic_a_d1", 32'(dout[0][1]), 32'hAA);
        check_eq("basic_b_early", 32'(vld[1][0]), 32'h0);
        step();
        check_eq("basic_b_d0", 32'(dout[1][0]), 32'h55);
        check_eq("basic_b_d1", 32'(dout[1][1]), 32'hAA);
        check_eq("basic_b_v1", 32'(vld[1][1]), 32'h1);

        // Write collision: port 0 wins.
        do_write(0, 8'h10, 8'h11);
        do_write(1, 8'h10, 8'h22);
        step();
        idle();
        check_eq("coll_a", 32'(coll[0]), 32'h1);
        check_eq("coll_b", 32'(coll[1]), 32'h1);
        step();
        do_read(0, 8'h10);
        step();
        idle();
        check_eq("coll_rd_a", 32'(dout[0][0]), 32'h11);
        step();
        check_eq("coll_rd_b", 32'(dout[1][0]), 32'h11);

        // Read-during-write.
        do_write(0, 8'h20, 8'h33);
        step();
        idle();
        do_write(0, 8'h20, 8'h44);
        do_read(1, 8'h20);
        step();
        idle();
        check_eq("rdw_old_a", 32'(dout[0][1]), 32'h33);
        step();
        check_eq("rdw_new_b", 32'(dout[1][1]), 32'h44);
        do_read(0, 8'h20);
        step();
        idle();
        check_eq("rdw_after_a", 32'(dout[0][0]), 32'h44);
        step();
        check_eq("rdw_after_b", 32'(dout[1][0]), 32'h44);

        // Out of range on the depth-200 instance.
        do_write(0, 8'hC8, 8'h77);
        step();
        idle();
        check_eq("oor_wr_err_b", 32'(aerr[1]), 32'h1);
        check_eq("oor_wr_err_a", 32'(aerr[0]), 32'h0);
        do_read(0, 8'hC8);
        step();
        idle();
        check_eq("oor_rd_err_b", 32'(aerr[1]), 32'h1);
        step();
        check_eq("oor_rd_b_data", 32'(dout[1][0]), 32'h00);
        check_eq("oor_rd_b_vld", 32'(vld[1][0]), 32'h1);
        // Sweep every in-range word through the model.
        for (int a = 0; a < 200; a += 2) begin
            do_read(0, 8'(a));
            do_read(1, 8'(a + 1));
            step();
        end
        idle();
        step();
        step();

        // Reset mid-operation with a read issued in the reset cycle.
        do_write(0, 8'h0A, 8'h99);
        step();
        idle();
        do_read(0, 8'h0A);
        rst = 1'b1;
        step();
        idle();
        rst = 1'b0;
        check_eq("rst_mid_vld_a", 32'(vld[0][0]), 32'h0);
        check_eq("rst_mid_busy_a", 32'(busy[0]), 32'h1);
        wait_clear(ca, cb);
        check_eq("rst_busy_len_a", 32'(ca), 32'd256);
        do_read(0, 8'h0A);
        step();
        idle();
        check_eq("rst_clr_a", 32'(dout[0][0]), 32'h00);
        step();
        check_eq("rst_clr_b", 32'(dout[1][0]), 32'h5A);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int p = 0; p < 2; p++) begin
                rd_en[p]   = 1'($urandom % 2);
                wr_en[p]   = 1'($urandom % 2);
                rd_addr[p] = rand_addr();
                wr_addr[p] = rand_addr();
                din[p]     = 8'($urandom);
            end
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_pipe.md
Name: dual_port_ram_pipe

Overview:
Parametrised true dual-port RAM. It generalises the existing two-port RAM with:
- a configurable read latency;
- a selectable read-during-write mode;
- deterministic write-collision arbitration;
- a post-reset hardware clear sequencer;
- an out-of-range address check.

It sits between datapath blocks as shared scratch storage. Both ports are fully independent read/write.

Parameters:
width, 8, data word width in bits
depth, 256, number of words; 1 <= depth <= 2**addr
addr, 8, address width in bits
rd_lat, 1, read latency in cycles; legal values 1 or 2
rdw_mode, 0, read-during-write to same address: 0 = old data (read-first), 1 = new data (write-first)
clr_val, 0, width-bit value written to every word by the clear sequencer

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
rd_en0  in  1  port 0 read request
wr_en0  in  1  port 0 write request
rd_addr0  in  addr  port 0 read address
wr_addr0  in  addr  port 0 write address
data_in0  in  width  port 0 write data
data_out0  out  width  port 0 read data
rd_valid0  out  1  port 0 read data valid, 1-cycle pulse per accepted read
rd_en1, wr_en1, rd_addr1, wr_addr1, data_in1, data_out1, rd_valid1: identical for port 1
init_busy  out  1  clear sequence in progress; requests are ignored
wr_collision  out  1  1-cycle pulse: both ports wrote the same address
addr_err  out  1  1-cycle pulse: any accepted request used an address >= depth

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values while rst=1: data_out0/1=0, rd_valid0/1=0, wr_collision=0, addr_err=0, init_busy=1, FSM=CLEAR, clr_ptr=0. Pipeline stages are flushed.
- FSM state CLEAR:
  - Each cycle with rst=0, write clr_val to mem[clr_ptr] and increment clr_ptr.
  - When clr_ptr==depth-1 is written, go to RUN on the next edge.
  - init_busy=1 throughout; it deasserts exactly depth cycles after rst falls.
  - All rd_en/wr_en are ignored: no writes, no rd_valid, no flags.
- FSM state RUN: normal operation. The only way back to CLEAR is rst.
- Reset mid-operation: in-flight reads are discarded (no rd_valid), the clear restarts from address 0, and memory contents are overwritten.
- Write: wr_enN sampled at the rising edge; mem[wr_addrN] is updated at that edge.
- Read, rd_lat=1: rd_enN sampled at edge k. data_outN and rd_validN are registered at edge k and are visible during cycle k+1.
- Read, rd_lat=2: adds one output register, so data is visible during cycle k+2.
- When no read completes, data_outN holds its last value and rd_validN=0.
- Both ports may read the same address in the same cycle; both return identical data.
- Write collision (wr_en0 & wr_en1 & wr_addr0==wr_addr1):
  - port 0 wins and port 1's write is dropped;
  - wr_collision=1 in the following cycle.
- Read-during-write, when either port's read address equals the winning write address in the same cycle:
  - rdw_mode=0 returns the pre-write contents;
  - rdw_mode=1 returns the winning write data (bypass).
- Out-of-range (address >= depth; only possible when depth < 2**addr):
  - the write is dropped;
  - the read returns 0 with rd_valid=1;
  - addr_err=1 in the following cycle.
- Flags are pulses: each is high for one cycle per offending cycle and is not sticky.
- Width rules: addresses are compared at full addr width with no wrap-around. clr_ptr is addr bits wide.

Decomposition:
- Package dual_port_ram_pkg:
  - FSM state typedef {CLEAR, RUN};
  - constants RDW_OLD=0 and RDW_NEW=1;
  - a function checking that rd_lat is in {1,2} and depth <= 2**addr (elaboration assertion).
- Sub-module ram_rd_pipe: per-port read-latency stage (data + valid shift register, depth rd_lat, flush on rst), instantiated twice.
- Top level holds the memory array, write arbitration, rdw bypass mux, clear FSM and flags.

Test Plan:
- Clear, defaults: rst high 2 cycles then low. init_busy must stay high exactly 256 cycles; then a read of 0xFF on port 1 returns 00 with rd_valid1 one cycle later.
- Basic access: port 0 writes 0xA=55 and port 1 writes 0xB=AA in the same cycle; next cycle read 0xA on port 0 and 0xB on port 1. Required: data_out0=55, data_out1=AA, both rd_valid high in the same cycle. With rd_lat=2, the identical result arrives one cycle later.
- Collision: both ports write 0x10, port 0 data 11, port 1 data 22. Required: wr_collision pulses once; a later read of 0x10 returns 11.
- Read-during-write: preload mem[0x20]=33. Port 0 writes 0x20=44 while port 1 reads 0x20. Required: data_out1=33 when rdw_mode=0, 44 when rdw_mode=1; a subsequent read returns 44 in both modes.
- Out-of-range, depth=200: write 0xC8=77, then read 0xC8. Required: addr_err pulses for each; read returns 00 with rd_valid=1; no word below 200 changes.
- Reset mid-operation: issue rd_en0 at 0x0A and assert rst in the same cycle. Required: no rd_valid0, init_busy reasserts, and after the clear 0x0A reads clr_val.
